// File: rtl/instruction_fetch_pkg.sv
// Shared widths, memory-FSM state encoding and the prefetch entry layout
// for the fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    M_IDLE    = 2'd0,
    M_WAIT    = 2'd1,
    M_DISCARD = 2'd2
  } mstate_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, redirect, and the
// DOR/ack_from_next handshake toward the decoder.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               DOR;
  logic               ack_from_next;
  logic [INSTR_W-1:0] data_out;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output mem_req, mem_addr, DOR, data_out, pc_out,
    input  mem_ack, mem_data, redirect, redirect_pc, ack_from_next
  );

  modport slave (
    input  mem_req, mem_addr, DOR, data_out, pc_out,
    output mem_ack, mem_data, redirect, redirect_pc, ack_from_next
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries. Flush wins over push and pop;
// callers guarantee no push when full and no pop when empty.
module instruction_fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      store  <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= wdata;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head = store[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads over req/ack into a prefetch
// FIFO and hands one instruction at a time to the decoder.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  mstate_t           mstate, mstate_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              mem_req_q, mem_req_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic              ack_q;
  logic              ack_edge;
  logic              push, pop, flush;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              credit;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  instruction_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_entry),
    .head  (head),
    .count (count)
  );

  // An outstanding request reserves a FIFO slot, so a push never meets a full FIFO.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, (mstate != M_IDLE)};
  assign credit    = occupancy < (CW + 1)'(FIFO_DEPTH);
  assign ack_edge  = bus.ack_from_next & ~ack_q;
  assign push_entry = '{pc: pc, instr: bus.mem_data};

  always_ff @(posedge clk) begin
    if (!reset) begin
      mstate     <= M_IDLE;
      pc         <= RESET_PC_ALIGNED;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC_ALIGNED;
      ack_q      <= 1'b0;
    end else begin
      mstate     <= mstate_n;
      pc         <= pc_n;
      mem_req_q  <= mem_req_n;
      mem_addr_q <= mem_addr_n;
      ack_q      <= bus.ack_from_next;
    end
  end

  always_comb begin
    mstate_n   = mstate;
    pc_n       = pc;
    mem_req_n  = mem_req_q;
    mem_addr_n = mem_addr_q;
    push       = 1'b0;
    flush      = bus.redirect;
    pop        = ack_edge & bus.DOR & ~bus.redirect;
    unique case (mstate)
      M_IDLE: begin
        // Holding off on redirect makes the next request use the new PC.
        if (credit && !bus.redirect) begin
          mem_req_n  = 1'b1;
          mem_addr_n = pc;
          mstate_n   = M_WAIT;
        end
      end
      M_WAIT: begin
        if (bus.mem_ack) begin
          push      = ~bus.redirect;
          pc_n      = pc + PC_STEP;
          mem_req_n = 1'b0;
          mstate_n  = M_IDLE;
        end else if (bus.redirect) begin
          mstate_n = M_DISCARD;
        end
      end
      M_DISCARD: begin
        if (bus.mem_ack) begin
          mem_req_n = 1'b0;
          mstate_n  = M_IDLE;
        end
      end
      default: mstate_n = M_IDLE;
    endcase
    if (bus.redirect) begin
      pc_n = word_align(bus.redirect_pc);
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.DOR      = (count != '0);
  assign bus.data_out = head.instr;
  assign bus.pc_out   = head.pc;

endmodule
